simd_exec_engine: RTL and testbench

//  Self-contained SIMD execution engine: host-loaded operand memories A/B, instruction memory, result memory R,

---
 rtl/simd_exec_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_simd_exec_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_exec_engine.sv
// -----------------------------------------------------------------------------
// simd_exec_engine
// Self-contained SIMD execution engine. The host loads operand memories A/B
// and the instruction memory. A start/busy/done controller then streams one
// instruction per cycle through fetch -> decode -> operand read -> PE_LATENCY
// ALU stages -> write into result memory R. The host reads R back through
// r_rd_addr/r_rd_data.
//
// Optional feature macro: SIMD_EXEC_PERF_EN builds the perf_cycles and
// perf_retired counters. When it is undefined, both ports are tied to zero.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               run request, only honoured in IDLE
//   stall               freezes pc, pipeline, R writes and FSM for the cycle
//   busy, done          busy in RUN/DRAIN; done is a 1-cycle pulse in DONE
//   err_pc_ovf          sticky: program ran to the last INS slot without END
//   a_wr_*, b_wr_*      host row writes to A/B (dropped while busy)
//   ins_wr_*            host instruction writes (dropped while busy)
//   r_rd_addr/r_rd_data host R read, 1-cycle latency, read-before-write
//   perf_cycles         busy cycles of the last run
//   perf_retired        R writes of the last run
// -----------------------------------------------------------------------------
module simd_exec_engine #(
    parameter int PE_COUNT       = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int BRAM_DEPTH     = 1024,
    parameter int ADDR_WIDTH     = $clog2(BRAM_DEPTH),
    parameter int INS_DEPTH      = 2048,
    parameter int INS_ADDR_WIDTH = $clog2(INS_DEPTH),
    parameter int OPCODE_WIDTH   = 4,
    parameter int PE_LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stall,
    output logic                           busy,
    output logic                           done,
    output logic                           err_pc_ovf,
    input  logic                           a_wr_en,
    input  logic [ADDR_WIDTH-1:0]          a_wr_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] a_wr_data,
    input  logic                           b_wr_en,
    input  logic [ADDR_WIDTH-1:0]          b_wr_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] b_wr_data,
    input  logic                           ins_wr_en,
    input  logic [INS_ADDR_WIDTH-1:0]      ins_wr_addr,
    input  logic [63:0]                    ins_wr_data,
    input  logic [ADDR_WIDTH-1:0]          r_rd_addr,
    output logic [PE_COUNT*DATA_WIDTH-1:0] r_rd_data,
    output logic [31:0]                    perf_cycles,
    output logic [31:0]                    perf_retired
);

    localparam int LANE_W  = PE_COUNT * DATA_WIDTH;
    localparam int FIELD_W = 3 * ADDR_WIDTH + OPCODE_WIDTH;
    localparam logic [OPCODE_WIDTH-1:0]   OP_ADD  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0]   OP_SUB  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0]   OP_MUL  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0]   OP_MAX  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0]   OP_END  = OPCODE_WIDTH'(15);
    localparam logic [INS_ADDR_WIDTH-1:0] PC_LAST = INS_ADDR_WIDTH'(INS_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [LANE_W-1:0]  a_mem_r   [BRAM_DEPTH];
    logic [LANE_W-1:0]  b_mem_r   [BRAM_DEPTH];
    logic [LANE_W-1:0]  r_mem_r   [BRAM_DEPTH];
    logic [FIELD_W-1:0] ins_mem_r [INS_DEPTH];

    state_t                    state_r, state_nxt_s;
    logic [INS_ADDR_WIDTH-1:0] pc_r;
    logic                      busy_r, done_r, err_r;
    logic                      f_vld_r, f_last_r;
    logic [FIELD_W-1:0]        ins_q_r;
    logic                      e_vld_r;
    logic [OPCODE_WIDTH-1:0]   e_op_r;
    logic [ADDR_WIDTH-1:0]     e_dst_r;
    logic [LANE_W-1:0]         a_q_r, b_q_r;
    logic [PE_LATENCY-1:0]     p_vld_r;
    logic [LANE_W-1:0]         p_res_r [PE_LATENCY];
    logic [ADDR_WIDTH-1:0]     p_dst_r [PE_LATENCY];

    logic [ADDR_WIDTH-1:0]     d_src_a_s, d_src_b_s, d_dst_s;
    logic [OPCODE_WIDTH-1:0]   d_op_s;
    logic                      d_wr_op_s, d_is_end_s, d_exec_s, d_ovf_s;
    logic                      fetch_s, start_acc_s, host_ok_s, r_wen_s, drain_empty_s;
    logic [LANE_W-1:0]         alu_s;
    logic                      ins_unused_s;

    assign ins_unused_s = ^ins_wr_data[63:FIELD_W];

    assign d_src_a_s = ins_q_r[ADDR_WIDTH-1:0];
    assign d_src_b_s = ins_q_r[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign d_dst_s   = ins_q_r[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
    assign d_op_s    = ins_q_r[FIELD_W-1:3*ADDR_WIDTH];

    // Opcodes that produce an R write; every other opcode behaves as NOP.
    always_comb begin
        d_wr_op_s = 1'b0;
        case (d_op_s)
            OP_ADD, OP_SUB, OP_MUL, OP_MAX: d_wr_op_s = 1'b1;
            default:                        d_wr_op_s = 1'b0;
        endcase
    end

    // The last INS slot always terminates the program; when it is not END the
    // overflow error is flagged and the slot itself is not executed.
    assign d_is_end_s  = f_vld_r & ((d_op_s == OP_END) | f_last_r);
    assign d_ovf_s     = f_vld_r & f_last_r & (d_op_s != OP_END);
    assign d_exec_s    = f_vld_r & ~d_is_end_s & d_wr_op_s;
    // Blocking fetch while END decodes squashes the one already-following slot.
    assign fetch_s     = (state_r == ST_RUN) & ~stall & ~d_is_end_s;
    assign start_acc_s = start & (state_r == ST_IDLE);
    assign host_ok_s   = (state_r == ST_IDLE) | (state_r == ST_DONE);
    assign r_wen_s     = p_vld_r[PE_LATENCY-1] & ~stall & ~rst;

    // Drain is complete once only the final (currently writing) stage may be valid.
    always_comb begin
        drain_empty_s = ~f_vld_r & ~e_vld_r;
        for (int k = 0; k < PE_LATENCY - 1; k++) begin
            drain_empty_s = drain_empty_s & ~p_vld_r[k];
        end
    end

    // Per-lane two's-complement ALU; results wrap.
    always_comb begin
        alu_s = {LANE_W{1'b0}};
        for (int l = 0; l < PE_COUNT; l++) begin
            case (e_op_r)
                OP_ADD:  alu_s[l*DATA_WIDTH +: DATA_WIDTH] = a_q_r[l*DATA_WIDTH +: DATA_WIDTH] + b_q_r[l*DATA_WIDTH +: DATA_WIDTH];
                OP_SUB:  alu_s[l*DATA_WIDTH +: DATA_WIDTH] = a_q_r[l*DATA_WIDTH +: DATA_WIDTH] - b_q_r[l*DATA_WIDTH +: DATA_WIDTH];
                OP_MUL:  alu_s[l*DATA_WIDTH +: DATA_WIDTH] = a_q_r[l*DATA_WIDTH +: DATA_WIDTH] * b_q_r[l*DATA_WIDTH +: DATA_WIDTH];
                OP_MAX:  alu_s[l*DATA_WIDTH +: DATA_WIDTH] =
                             ($signed(a_q_r[l*DATA_WIDTH +: DATA_WIDTH]) > $signed(b_q_r[l*DATA_WIDTH +: DATA_WIDTH]))
                             ? a_q_r[l*DATA_WIDTH +: DATA_WIDTH] : b_q_r[l*DATA_WIDTH +: DATA_WIDTH];
                default: alu_s[l*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            endcase
        end
    end

    // Run-controller next-state logic; RUN and DRAIN hold while stalled.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) state_nxt_s = ST_RUN; else state_nxt_s = ST_IDLE;
            ST_RUN:   if (~stall & d_is_end_s) state_nxt_s = ST_DRAIN; else state_nxt_s = ST_RUN;
            ST_DRAIN: if (~stall & drain_empty_s) state_nxt_s = ST_DONE; else state_nxt_s = ST_DRAIN;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, pc and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= {INS_ADDR_WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN) | (state_nxt_s == ST_DRAIN);
            done_r  <= (state_nxt_s == ST_DONE);
            if (start_acc_s) begin
                pc_r  <= {INS_ADDR_WIDTH{1'b0}};
                err_r <= 1'b0;
            end else begin
                if (fetch_s) pc_r <= pc_r + INS_ADDR_WIDTH'(1);
                if (~stall & d_ovf_s) err_r <= 1'b1;
            end
        end
    end

    // Pipeline valid bits; only R-writing instructions travel past decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_vld_r  <= 1'b0;
            f_last_r <= 1'b0;
            e_vld_r  <= 1'b0;
            p_vld_r  <= {PE_LATENCY{1'b0}};
        end else if (~stall) begin
            f_vld_r    <= fetch_s;
            f_last_r   <= fetch_s & (pc_r == PC_LAST);
            e_vld_r    <= d_exec_s;
            p_vld_r[0] <= e_vld_r;
            for (int k = 1; k < PE_LATENCY; k++) p_vld_r[k] <= p_vld_r[k-1];
        end
    end

    // Pipeline payload registers, frozen by stall.
    always_ff @(posedge clk) begin
        if (~stall) begin
            e_op_r     <= d_op_s;
            e_dst_r    <= d_dst_s;
            p_res_r[0] <= alu_s;
            p_dst_r[0] <= e_dst_r;
            for (int k = 1; k < PE_LATENCY; k++) begin
                p_res_r[k] <= p_res_r[k-1];
                p_dst_r[k] <= p_dst_r[k-1];
            end
        end
    end

    // Instruction memory: host write port plus fetch read port.
    always_ff @(posedge clk) begin
        if (ins_wr_en & host_ok_s) ins_mem_r[ins_wr_addr] <= ins_wr_data[FIELD_W-1:0];
        if (fetch_s) ins_q_r <= ins_mem_r[pc_r];
    end

    // Operand memories: host write ports plus decode-driven read ports.
    always_ff @(posedge clk) begin
        if (a_wr_en & host_ok_s) a_mem_r[a_wr_addr] <= a_wr_data;
        if (b_wr_en & host_ok_s) b_mem_r[b_wr_addr] <= b_wr_data;
        if (d_exec_s & ~stall) begin
            a_q_r <= a_mem_r[d_src_a_s];
            b_q_r <= b_mem_r[d_src_b_s];
        end
    end

    // Result memory: engine write port and host read port (read-before-write).
    always_ff @(posedge clk) begin
        if (r_wen_s) r_mem_r[p_dst_r[PE_LATENCY-1]] <= p_res_r[PE_LATENCY-1];
        r_rd_data <= r_mem_r[r_rd_addr];
    end

`ifdef SIMD_EXEC_PERF_EN
    logic [31:0] perf_cycles_r, perf_retired_r;

    // Saturating run counters, cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (rst | start_acc_s) begin
            perf_cycles_r  <= 32'd0;
            perf_retired_r <= 32'd0;
        end else begin
            if (busy_r && (perf_cycles_r != 32'hFFFF_FFFF)) perf_cycles_r <= perf_cycles_r + 32'd1;
            if (r_wen_s && (perf_retired_r != 32'hFFFF_FFFF)) perf_retired_r <= perf_retired_r + 32'd1;
        end
    end

    assign perf_cycles  = perf_cycles_r;
    assign perf_retired = perf_retired_r;
`else
    assign perf_cycles  = 32'd0;
    assign perf_retired = 32'd0;
`endif

    assign busy       = busy_r;
    assign done       = done_r;
    assign err_pc_ovf = err_r;

endmodule

// File: tb/tb_simd_exec_engine.sv
// -----------------------------------------------------------------------------
// tb_simd_exec_engine
// Directed self-checking bench for simd_exec_engine (default parameters).
// Expected values are hand-computed constants or small per-lane arithmetic.
// -----------------------------------------------------------------------------
module tb_simd_exec_engine;

    localparam int AW  = 10;
    localparam int IAW = 11;
    localparam int LW  = 256;
`ifdef SIMD_EXEC_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, start, stall;
    logic           busy, done, err_pc_ovf;
    logic           a_wr_en, b_wr_en, ins_wr_en;
    logic [AW-1:0]  a_wr_addr, b_wr_addr, r_rd_addr;
    logic [LW-1:0]  a_wr_data, b_wr_data, r_rd_data;
    logic [IAW-1:0] ins_wr_addr;
    logic [63:0]    ins_wr_data;
    logic [31:0]    perf_cycles, perf_retired;

    int checks   = 0;
    int failures = 0;
    int dc;
    logic b1, bd, seen_done;
    logic [LW-1:0] rd_v;

    logic [31:0] t4_a   [8] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'd7,  32'h8000_0000, 32'd3,         32'd100,   32'hFFFF_FFFE, 32'd12};
    logic [31:0] t4_b   [8] = '{32'h0001_0000, 32'd5,         32'd6,  32'd1,         32'hFFFF_FFFD, 32'd200,   32'hFFFF_FFFF, 32'd0};
    logic [31:0] t4_mul [8] = '{32'd0,         32'hFFFF_FFFB, 32'd42, 32'h8000_0000, 32'hFFFF_FFF7, 32'd20000, 32'd2,         32'd0};
    logic [31:0] t4_max [8] = '{32'h0001_0000, 32'd5,         32'd7,  32'd1,         32'd3,         32'd200,   32'hFFFF_FFFF, 32'd12};
    logic [31:0] t4_add [8] = '{32'h0002_0000, 32'd4,         32'd13, 32'h8000_0001, 32'd0,         32'd300,   32'hFFFF_FFFD, 32'd12};

    always #5 clk = ~clk;

    simd_exec_engine dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy), .done(done), .err_pc_ovf(err_pc_ovf),
        .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .ins_wr_en(ins_wr_en), .ins_wr_addr(ins_wr_addr), .ins_wr_data(ins_wr_data),
        .r_rd_addr(r_rd_addr), .r_rd_data(r_rd_data),
        .perf_cycles(perf_cycles), .perf_retired(perf_retired)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] enc(input logic [3:0] op, input logic [AW-1:0] dst,
                                        input logic [AW-1:0] sb, input logic [AW-1:0] sa);
        enc = {30'd0, op, dst, sb, sa};
    endfunction

    function automatic logic [LW-1:0] pack(input logic [31:0] v [8]);
        for (int l = 0; l < 8; l++) pack[l*32 +: 32] = v[l];
    endfunction

    function automatic logic [LW-1:0] row_a(input int i);
        for (int l = 0; l < 8; l++) row_a[l*32 +: 32] = 32'(i * 1000 + l * 7 + 5);
    endfunction

    function automatic logic [LW-1:0] row_b(input int i);
        for (int l = 0; l < 8; l++) row_b[l*32 +: 32] = 32'(l * 300 + i * 3 + 1);
    endfunction

    function automatic logic [LW-1:0] row_sub(input int i);
        logic [LW-1:0] a, b;
        a = row_a(i);
        b = row_b(i);
        for (int l = 0; l < 8; l++) row_sub[l*32 +: 32] = a[l*32 +: 32] - b[l*32 +: 32];
    endfunction

    task automatic wr_ab(input int addr, input logic [LW-1:0] a, input logic [LW-1:0] b);
        a_wr_en = 1'b1; b_wr_en = 1'b1;
        a_wr_addr = AW'(addr); b_wr_addr = AW'(addr);
        a_wr_data = a; b_wr_data = b;
        tick;
        a_wr_en = 1'b0; b_wr_en = 1'b0;
    endtask

    task automatic wr_ins(input int addr, input logic [63:0] d);
        ins_wr_en = 1'b1; ins_wr_addr = IAW'(addr); ins_wr_data = d;
        tick;
        ins_wr_en = 1'b0;
    endtask

    task automatic rd_r(input int addr, output logic [LW-1:0] d);
        r_rd_addr = AW'(addr);
        tick;
        d = r_rd_data;
    endtask

    // Start a run; returns the cycle (1 = first busy cycle) where done is seen, -1 on timeout.
    task automatic run(input int stall_from, input int stall_len, input int poke_at, input int limit,
                       output int done_cyc, output logic busy1, output logic busy_done);
        int cyc;
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        done_cyc = -1;
        busy1 = busy;
        busy_done = 1'b1;
        while (cyc <= limit) begin
            if (done) begin
                done_cyc = cyc;
                busy_done = busy;
                break;
            end
            stall = (cyc >= stall_from) && (cyc < stall_from + stall_len);
            a_wr_en = (cyc == poke_at);
            a_wr_addr = AW'(1);
            a_wr_data = {8{32'hDEAD_BEEF}};
            tick;
            cyc++;
        end
        stall = 1'b0;
        a_wr_en = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] a0, b0, s0;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        a_wr_en = 1'b0; b_wr_en = 1'b0; ins_wr_en = 1'b0;
        a_wr_addr = '0; b_wr_addr = '0; r_rd_addr = '0; ins_wr_addr = '0;
        a_wr_data = '0; b_wr_data = '0; ins_wr_data = '0;
        tick; tick;
        rst = 1'b0;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_err", 256'(err_pc_ovf), 256'(0));
        chk("rst_perf_cycles", 256'(perf_cycles), 256'(0));
        chk("rst_perf_retired", 256'(perf_retired), 256'(0));

        for (int i = 0; i < 2048; i++) wr_ins(i, 64'd0);

        // Single ADD then END.
        for (int l = 0; l < 8; l++) begin
            a0[l*32 +: 32] = 32'(l + 1);
            b0[l*32 +: 32] = 32'(10 * (l + 1));
            s0[l*32 +: 32] = 32'(11 * (l + 1));
        end
        wr_ab(0, a0, b0);
        wr_ins(0, enc(4'd1, 10'd0, 10'd0, 10'd0));
        wr_ins(1, enc(4'd15, 10'd0, 10'd0, 10'd0));
        run(0, 0, -1, 50, dc, b1, bd);
        chk("t1_done_cycle", 256'(dc), 256'(6));
        chk("t1_busy_cycle1", 256'(b1), 256'(1));
        chk("t1_busy_at_done", 256'(bd), 256'(0));
        tick;
        chk("t1_done_one_pulse", 256'(done), 256'(0));
        chk("t1_perf_cycles", 256'(perf_cycles), 256'(PERF_ON ? 5 : 0));
        chk("t1_perf_retired", 256'(perf_retired), 256'(PERF_ON ? 1 : 0));
        rd_r(0, rd_v);
        chk("t1_r0", rd_v, s0);

        // Program of NOPs only: runs off the end of INS.
        wr_ins(0, 64'd0);
        wr_ins(1, 64'd0);
        run(0, 0, -1, 3000, dc, b1, bd);
        chk("ovf_done_cycle", 256'(dc), 256'(2051));
        chk("ovf_err_set", 256'(err_pc_ovf), 256'(1));
        tick;
        chk("ovf_err_sticky", 256'(err_pc_ovf), 256'(1));
        chk("ovf_perf_cycles", 256'(perf_cycles), 256'(PERF_ON ? 2050 : 0));
        chk("ovf_perf_retired", 256'(perf_retired), 256'(0));
        rd_r(0, rd_v);
        chk("ovf_r0_untouched", rd_v, s0);

        // 256 back-to-back SUBs then END.
        for (int i = 0; i < 256; i++) begin
            wr_ab(i, row_a(i), row_b(i));
            wr_ins(i, enc(4'd2, AW'(i), AW'(i), AW'(i)));
        end
        wr_ins(256, enc(4'd15, 10'd0, 10'd0, 10'd0));
        run(0, 0, -1, 400, dc, b1, bd);
        chk("sub_done_cycle", 256'(dc), 256'(261));
        chk("sub_err_cleared", 256'(err_pc_ovf), 256'(0));
        tick;
        chk("sub_perf_cycles", 256'(perf_cycles), 256'(PERF_ON ? 260 : 0));
        chk("sub_perf_retired", 256'(perf_retired), 256'(PERF_ON ? 256 : 0));
        for (int i = 0; i < 256; i++) begin
            rd_r(i, rd_v);
            chk($sformatf("sub_r%0d", i), rd_v, row_sub(i));
        end

        // Same program with a 3-cycle stall mid-run.
        run(100, 3, -1, 400, dc, b1, bd);
        chk("stall_done_cycle", 256'(dc), 256'(264));
        tick;
        chk("stall_perf_cycles", 256'(perf_cycles), 256'(PERF_ON ? 263 : 0));
        chk("stall_perf_retired", 256'(perf_retired), 256'(PERF_ON ? 256 : 0));
        for (int i = 0; i < 256; i += 17) begin
            rd_r(i, rd_v);
            chk($sformatf("stall_r%0d", i), rd_v, row_sub(i));
        end
        rd_r(255, rd_v);
        chk("stall_r255", rd_v, row_sub(255));

        // MUL / MAX / undefined opcode, with a host A write attempted while busy.
        wr_ab(1, pack(t4_a), pack(t4_b));
        wr_ins(0, enc(4'd3, 10'd300, 10'd1, 10'd1));
        wr_ins(1, enc(4'd4, 10'd301, 10'd1, 10'd1));
        wr_ins(2, enc(4'd7, 10'd2, 10'd1, 10'd1));
        wr_ins(3, enc(4'd15, 10'd0, 10'd0, 10'd0));
        run(0, 0, 3, 50, dc, b1, bd);
        chk("ops_done_cycle", 256'(dc), 256'(7));
        tick;
        chk("ops_perf_retired", 256'(perf_retired), 256'(PERF_ON ? 2 : 0));
        rd_r(300, rd_v);
        chk("ops_mul", rd_v, pack(t4_mul));
        rd_r(301, rd_v);
        chk("ops_max", rd_v, pack(t4_max));
        rd_r(2, rd_v);
        chk("ops_op7_no_write", rd_v, row_sub(2));

        // Reset two cycles into a run, then a clean rerun.
        wr_ins(0, enc(4'd1, 10'd3, 10'd1, 10'd1));
        wr_ins(1, enc(4'd15, 10'd0, 10'd0, 10'd0));
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_busy", 256'(busy), 256'(0));
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done) seen_done = 1'b1;
            tick;
        end
        chk("rst_mid_no_done", 256'(seen_done), 256'(0));
        rd_r(3, rd_v);
        chk("rst_mid_r3_untouched", rd_v, row_sub(3));
        run(0, 0, -1, 50, dc, b1, bd);
        chk("rerun_done_cycle", 256'(dc), 256'(6));
        tick;
        chk("rerun_perf_retired", 256'(perf_retired), 256'(PERF_ON ? 1 : 0));
        rd_r(3, rd_v);
        chk("rerun_r3_a_unchanged", rd_v, pack(t4_add));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
